// File: rtl/print_module.sv
// ---------------------------------------------------------------------------
// print_module
//   Sprite print unit. Compares the current VGA pixel position against one
//   sprite descriptor and, on a hit, walks the memory addresses of the
//   matching sprite line (one address per pixel tick) for the sprite memory.
//
// Ports
//   clk             : system clock
//   reset           : asynchronous, active-high; clears all state
//   pixel_en        : one-clk pulse per pixel period
//   data_reg        : sprite descriptor {en, offset[8:0], x[9:0], y[8:0], rsvd[2:0]}
//   active_area     : pixel is in the visible region
//   pixel_x/pixel_y : current pixel position
//   memory_address  : sprite memory read address (0 when not counting)
//   printtingScreen : sprite pixel being output
//   sprite_on       : line counter running
//   count_finished  : one-clk pulse at end of a sprite line
//   check_value     : registered {x, y} of the last descriptor sampled in IDLE
// ---------------------------------------------------------------------------
module print_module #(
    parameter int size_x       = 10,
    parameter int size_y       = 9,
    parameter int size_address = 17,
    parameter int bits_x_y     = 19,
    parameter int size_line    = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pixel_en,
    input  logic [31:0]             data_reg,
    input  logic                    active_area,
    input  logic [size_x-1:0]       pixel_x,
    input  logic [size_y-1:0]       pixel_y,
    output logic [size_address-1:0] memory_address,
    output logic                    printtingScreen,
    output logic                    sprite_on,
    output logic                    count_finished,
    output logic [bits_x_y-1:0]     check_value
);

    localparam int cnt_w  = $clog2(size_line);
    localparam int off_w  = 9;
    // Address arithmetic width: wide enough for 511*400 + 399 without wrap.
    localparam int calc_w = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [off_w-1:0]     offset_r, offset_nxt_s;
    logic [cnt_w-1:0]     row_r, row_nxt_s;
    logic [cnt_w-1:0]     col_r, col_nxt_s;
    logic [bits_x_y-1:0]  check_value_r, check_nxt_s;

    // Descriptor fields
    logic                 desc_en_s;
    logic [off_w-1:0]     desc_off_s;
    logic [size_x-1:0]    desc_x_s;
    logic [size_y-1:0]    desc_y_s;

    assign desc_en_s  = data_reg[31];
    assign desc_off_s = data_reg[30:22];
    assign desc_x_s   = data_reg[21:12];
    assign desc_y_s   = data_reg[11:3];

    // Row compare is done one bit wider than pixel_y so a pixel_y below y
    // cannot wrap into a small positive row number.
    logic [size_y:0] row_diff_s;
    logic            hit_s;

    assign row_diff_s = {1'b0, pixel_y} - {1'b0, desc_y_s};
    assign hit_s      = desc_en_s && active_area && (pixel_x == desc_x_s) &&
                        (pixel_y >= desc_y_s) &&
                        (row_diff_s < (size_y+1)'(size_line));

    // Next-state and next-register computation
    always_comb begin
        state_nxt_s  = state_r;
        offset_nxt_s = offset_r;
        row_nxt_s    = row_r;
        col_nxt_s    = col_r;
        check_nxt_s  = check_value_r;
        case (state_r)
            IDLE: begin
                check_nxt_s = {desc_x_s, desc_y_s};
                if (hit_s) begin
                    offset_nxt_s = desc_off_s;
                    row_nxt_s    = row_diff_s[cnt_w-1:0];
                    col_nxt_s    = {cnt_w{1'b0}};
                    state_nxt_s  = COUNT;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            COUNT: begin
                // Leaving the visible area aborts the line without a finish pulse.
                if (!active_area) begin
                    state_nxt_s = IDLE;
                end else if (pixel_en) begin
                    if (col_r == cnt_w'(size_line - 1)) begin
                        state_nxt_s = DONE;
                    end else begin
                        col_nxt_s = col_r + {{(cnt_w-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_nxt_s = COUNT;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and working registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            offset_r      <= {off_w{1'b0}};
            row_r         <= {cnt_w{1'b0}};
            col_r         <= {cnt_w{1'b0}};
            check_value_r <= {bits_x_y{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            offset_r      <= offset_nxt_s;
            row_r         <= row_nxt_s;
            col_r         <= col_nxt_s;
            check_value_r <= check_nxt_s;
        end
    end

    // Address = offset*line^2 + row*line + col, truncated to the port width.
    logic [calc_w-1:0] addr_full_s;

    assign addr_full_s = ({{(calc_w-off_w){1'b0}}, offset_r} * calc_w'(size_line * size_line)) +
                         ({{(calc_w-cnt_w){1'b0}}, row_r} * calc_w'(size_line)) +
                         {{(calc_w-cnt_w){1'b0}}, col_r};

    assign memory_address  = (state_r == COUNT) ? addr_full_s[size_address-1:0]
                                                : {size_address{1'b0}};
    assign sprite_on       = (state_r == COUNT);
    assign printtingScreen = (state_r == COUNT);
    assign count_finished  = (state_r == DONE);
    assign check_value     = check_value_r;

endmodule

// File: tb/tb_print_module.sv
module tb_print_module;

    logic        clk;
    logic        reset;
    logic        pixel_en;
    logic [31:0] data_reg;
    logic        active_area;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [16:0] memory_address;
    logic        printtingScreen;
    logic        sprite_on;
    logic        count_finished;
    logic [18:0] check_value;

    int pass_cnt;
    int total_cnt;

    print_module dut (
        .clk            (clk),
        .reset          (reset),
        .pixel_en       (pixel_en),
        .data_reg       (data_reg),
        .active_area    (active_area),
        .pixel_x        (pixel_x),
        .pixel_y        (pixel_y),
        .memory_address (memory_address),
        .printtingScreen(printtingScreen),
        .sprite_on      (sprite_on),
        .count_finished (count_finished),
        .check_value    (check_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] desc(input logic en, input logic [8:0] off,
                                         input logic [9:0] x, input logic [8:0] y);
        return {en, off, x, y, 3'b000};
    endfunction

    // One clock edge with the given pixel_en, then settle 1 time unit.
    task automatic step(input logic pe);
        pixel_en = pe;
        @(posedge clk);
        #1;
        pixel_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; pixel_en = 1'b0; active_area = 1'b1;
        data_reg = desc(1'b1, 9'd2, 10'd100, 9'd50);
        pixel_x = 10'd100; pixel_y = 9'd53;
        step(1'b0); step(1'b0);
        total_cnt++;
        if ({memory_address, printtingScreen, sprite_on, count_finished, check_value} !== 39'd0)
            $display("FAIL reset_outputs: addr=%0d ps=%b on=%b fin=%b cv=%h, required all 0",
                     memory_address, printtingScreen, sprite_on, count_finished, check_value);
        else pass_cnt++;
        reset = 1'b0;
        data_reg = desc(1'b0, 9'd2, 10'd100, 9'd50);
        step(1'b0);
        total_cnt++;
        if (sprite_on !== 1'b0 || memory_address !== 17'd0)
            $display("FAIL disabled_no_hit: on=%b addr=%0d, required 0/0", sprite_on, memory_address);
        else pass_cnt++;
        total_cnt++;
        if (check_value !== {10'd100, 9'd50})
            $display("FAIL check_value_track: got %h, required %h", check_value, {10'd100, 9'd50});
        else pass_cnt++;
    endtask

    task automatic test_line;
        data_reg = desc(1'b1, 9'd2, 10'd100, 9'd50);
        pixel_x = 10'd100; pixel_y = 9'd53; active_area = 1'b1;
        step(1'b0);
        total_cnt++;
        if (sprite_on !== 1'b1 || printtingScreen !== 1'b1 || memory_address !== 17'd860)
            $display("FAIL line_hit: on=%b ps=%b addr=%0d, required 1/1/860",
                     sprite_on, printtingScreen, memory_address);
        else pass_cnt++;
        // Inputs ignored while counting; descriptor change must not disturb anything.
        pixel_x = 10'd300;
        data_reg = desc(1'b0, 9'd5, 10'd7, 9'd9);
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 3; j++) begin
                step(1'b0);
                total_cnt++;
                if (sprite_on !== 1'b1 || memory_address !== 17'(860 + k))
                    $display("FAIL line_hold k=%0d: on=%b addr=%0d, required 1/%0d",
                             k, sprite_on, memory_address, 860 + k);
                else pass_cnt++;
            end
            step(1'b1);
            total_cnt++;
            if (k < 19) begin
                if (sprite_on !== 1'b1 || count_finished !== 1'b0 || memory_address !== 17'(861 + k))
                    $display("FAIL line_step k=%0d: on=%b fin=%b addr=%0d, required 1/0/%0d",
                             k, sprite_on, count_finished, memory_address, 861 + k);
                else pass_cnt++;
            end else begin
                if (sprite_on !== 1'b0 || count_finished !== 1'b1 || memory_address !== 17'd0)
                    $display("FAIL line_done: on=%b fin=%b addr=%0d, required 0/1/0",
                             sprite_on, count_finished, memory_address);
                else pass_cnt++;
            end
            total_cnt++;
            if (k == 10 && check_value !== {10'd100, 9'd50})
                $display("FAIL check_value_hold: got %h, required %h", check_value, {10'd100, 9'd50});
            else pass_cnt++;
        end
        step(1'b0);
        total_cnt++;
        if (count_finished !== 1'b0 || sprite_on !== 1'b0)
            $display("FAIL line_idle: fin=%b on=%b, required 0/0", count_finished, sprite_on);
        else pass_cnt++;
        step(1'b0);
        total_cnt++;
        if (check_value !== {10'd7, 9'd9})
            $display("FAIL check_value_resume: got %h, required %h", check_value, {10'd7, 9'd9});
        else pass_cnt++;
    endtask

    task automatic test_row_bounds;
        data_reg = desc(1'b1, 9'd2, 10'd100, 9'd50);
        pixel_x = 10'd100; active_area = 1'b1;
        pixel_y = 9'd70;
        step(1'b0);
        total_cnt++;
        if (sprite_on !== 1'b0)
            $display("FAIL row20_no_hit: on=%b, required 0", sprite_on);
        else pass_cnt++;
        pixel_y = 9'd49;
        step(1'b0);
        total_cnt++;
        if (sprite_on !== 1'b0)
            $display("FAIL row_below_no_hit: on=%b, required 0", sprite_on);
        else pass_cnt++;
        pixel_y = 9'd53; active_area = 1'b0;
        step(1'b0);
        total_cnt++;
        if (sprite_on !== 1'b0)
            $display("FAIL inactive_no_hit: on=%b, required 0", sprite_on);
        else pass_cnt++;
        active_area = 1'b1; pixel_y = 9'd69;
        step(1'b0);
        total_cnt++;
        if (sprite_on !== 1'b1 || memory_address !== 17'd1180)
            $display("FAIL row19_hit: on=%b addr=%0d, required 1/1180", sprite_on, memory_address);
        else pass_cnt++;
        pixel_x = 10'd300;
        for (int k = 0; k < 7; k++) step(1'b1);
        total_cnt++;
        if (memory_address !== 17'd1187)
            $display("FAIL abort_col7: addr=%0d, required 1187", memory_address);
        else pass_cnt++;
        active_area = 1'b0;
        step(1'b0);
        total_cnt++;
        if (sprite_on !== 1'b0 || count_finished !== 1'b0 || memory_address !== 17'd0)
            $display("FAIL abort_idle: on=%b fin=%b addr=%0d, required 0/0/0",
                     sprite_on, count_finished, memory_address);
        else pass_cnt++;
        step(1'b0);
        total_cnt++;
        if (count_finished !== 1'b0)
            $display("FAIL abort_no_finish: fin=%b, required 0", count_finished);
        else pass_cnt++;
        active_area = 1'b1;
    endtask

    task automatic test_wrap;
        data_reg = desc(1'b1, 9'd511, 10'd5, 9'd0);
        pixel_x = 10'd5; pixel_y = 9'd19; active_area = 1'b1;
        step(1'b0);
        total_cnt++;
        if (memory_address !== 17'd73708)
            $display("FAIL wrap_base: addr=%0d, required 73708", memory_address);
        else pass_cnt++;
        pixel_x = 10'd300;
        for (int k = 0; k < 19; k++) step(1'b1);
        total_cnt++;
        if (memory_address !== 17'd73727 || sprite_on !== 1'b1)
            $display("FAIL wrap_last: addr=%0d on=%b, required 73727/1", memory_address, sprite_on);
        else pass_cnt++;
        step(1'b1);
        total_cnt++;
        if (count_finished !== 1'b1)
            $display("FAIL wrap_done: fin=%b, required 1", count_finished);
        else pass_cnt++;
        step(1'b0);
    endtask

    task automatic test_reset_mid;
        data_reg = desc(1'b1, 9'd2, 10'd100, 9'd50);
        pixel_x = 10'd100; pixel_y = 9'd53; active_area = 1'b1;
        step(1'b0);
        pixel_x = 10'd300;
        for (int k = 0; k < 10; k++) step(1'b1);
        total_cnt++;
        if (memory_address !== 17'd870)
            $display("FAIL mid_col10: addr=%0d, required 870", memory_address);
        else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({memory_address, printtingScreen, sprite_on, count_finished, check_value} !== 39'd0)
            $display("FAIL async_reset: addr=%0d ps=%b on=%b fin=%b cv=%h, required all 0",
                     memory_address, printtingScreen, sprite_on, count_finished, check_value);
        else pass_cnt++;
        step(1'b0);
        reset = 1'b0;
        pixel_x = 10'd100;
        step(1'b0);
        total_cnt++;
        if (sprite_on !== 1'b1 || memory_address !== 17'd860)
            $display("FAIL restart_col0: on=%b addr=%0d, required 1/860", sprite_on, memory_address);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_line();
        test_row_bounds();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
